prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 95 +++++++++
 tb/tb_prbs_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Checker for a 19-bit XNOR PRBS carried as 5-bit FSK symbols (MSB = newest bit).
// It acquires the generator state from received bits, then flywheels and counts errors.
module prbs_checker #(
  parameter int LOSS_THRESH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [4:0]           INDATA,
  input  logic                 CLEAR,
  output logic                 LOCKED,
  output logic                 ERROR,
  output logic [CNT_WIDTH-1:0] ERRCOUNT,
  output logic [CNT_WIDTH-1:0] SYMCOUNT
);

  typedef enum logic {ACQUIRE, CHECK} state_t;

  localparam logic [3:0]           THRESH  = 4'(LOSS_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t      state, state_next;
  logic [18:0] loc, loc_next;
  logic [4:0]  fill, fill_next;
  logic [3:0]  miss, miss_next;
  logic [4:0]  predicted;
  logic        check_strobe;
  logic        mismatch;

  always_comb begin
    predicted    = {~(loc[18] ^ loc[5] ^ loc[1] ^ loc[0]), loc[18:15]};
    check_strobe = ENABLE && (state == CHECK);
    mismatch     = check_strobe && (INDATA != predicted);
    state_next   = state;
    loc_next     = loc;
    fill_next    = fill;
    miss_next    = miss;
    if (ENABLE) begin
      case (state)
        ACQUIRE: begin
          loc_next  = {INDATA[4], loc[18:1]};
          fill_next = fill + 5'd1;
          // All-ones is the XNOR lock-up state; refuse it and refill from scratch.
          if (fill == 5'd18) begin
            if (loc_next == '1) fill_next = '0;
            else                state_next = CHECK;
          end
        end
        CHECK: begin
          loc_next = {predicted[4], loc[18:1]};
          if (mismatch) begin
            if (miss + 4'd1 == THRESH) begin
              state_next = ACQUIRE;
              fill_next  = '0;
              miss_next  = '0;
            end else begin
              miss_next = miss + 4'd1;
            end
          end else begin
            miss_next = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ACQUIRE;
      loc      <= '0;
      fill     <= '0;
      miss     <= '0;
      ERROR    <= 1'b0;
      ERRCOUNT <= '0;
      SYMCOUNT <= '0;
    end else begin
      state <= state_next;
      loc   <= loc_next;
      fill  <= fill_next;
      miss  <= miss_next;
      ERROR <= mismatch;
      if (CLEAR) begin
        ERRCOUNT <= '0;
        SYMCOUNT <= '0;
      end else begin
        if (check_strobe && (SYMCOUNT != '1)) SYMCOUNT <= SYMCOUNT + CNT_ONE;
        if (mismatch && (ERRCOUNT != '1))     ERRCOUNT <= ERRCOUNT + CNT_ONE;
      end
    end
  end

  assign LOCKED = (state == CHECK);

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: behavioural model plus directed tables, lock-up, gapped,
// random and small-counter saturation scenarios.
module tb_prbs_checker;

  logic        CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic        rst, en, clr;
  logic [4:0]  din;
  logic        locked, error;
  logic [15:0] errc, symc;

  logic        rst_s, en_s, clr_s;
  logic [4:0]  din_s;
  logic        locked_s, error_s;
  logic [3:0]  errc_s, symc_s;

  prbs_checker dut (
    .CLOCK(CLOCK), .RESET(rst), .ENABLE(en), .INDATA(din), .CLEAR(clr),
    .LOCKED(locked), .ERROR(error), .ERRCOUNT(errc), .SYMCOUNT(symc)
  );

  prbs_checker #(.LOSS_THRESH(15), .CNT_WIDTH(4)) dut_s (
    .CLOCK(CLOCK), .RESET(rst_s), .ENABLE(en_s), .INDATA(din_s), .CLEAR(clr_s),
    .LOCKED(locked_s), .ERROR(error_s), .ERRCOUNT(errc_s), .SYMCOUNT(symc_s)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [18:0] prbs_next(input logic [18:0] s);
    return {~(s[18] ^ s[5] ^ s[1] ^ s[0]), s[18:1]};
  endfunction

  // Transmit-side generator: emit the current symbol, then advance.
  logic [18:0] g;
  task automatic gen_pop(output logic [4:0] s);
    s = g[18:14];
    g = prbs_next(g);
  endtask

  // Reference model of the default-parameter checker.
  localparam int THRESH = 4;
  localparam int CMAX   = 65535;
  logic [18:0] m_loc;
  int          m_fill, m_miss, m_err, m_sym;
  bit          m_lock, m_errp;

  task automatic model_reset();
    m_loc = '0; m_fill = 0; m_miss = 0; m_err = 0; m_sym = 0; m_lock = 0; m_errp = 0;
  endtask

  task automatic model_step(input logic e, input logic [4:0] d, input logic c);
    logic [18:0] nxt;
    m_errp = 0;
    if (e) begin
      if (!m_lock) begin
        m_loc = {d[4], m_loc[18:1]};
        m_fill++;
        if (m_fill == 19) begin
          if (m_loc == 19'h7FFFF) m_fill = 0;
          else m_lock = 1;
        end
      end else begin
        // Once locked the model is simply the generator: predict its next symbol.
        nxt   = prbs_next(m_loc);
        m_loc = nxt;
        m_sym = (m_sym < CMAX) ? m_sym + 1 : CMAX;
        if (d != nxt[18:14]) begin
          m_errp = 1;
          m_err  = (m_err < CMAX) ? m_err + 1 : CMAX;
          m_miss++;
          if (m_miss == THRESH) begin
            m_lock = 0; m_fill = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) begin
      m_err = 0; m_sym = 0;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [4:0] d, input logic c);
    rst = r; en = e; din = d; clr = c;
    if (r) model_reset();
    else   model_step(e, d, c);
    @(posedge CLOCK); #1;
    check("locked",   32'(locked), 32'(m_lock));
    check("error",    32'(error),  32'(m_errp));
    check("errcount", 32'(errc),   32'(m_err));
    check("symcount", 32'(symc),   32'(m_sym));
  endtask

  task automatic feed_good(input int n);
    logic [4:0] s;
    for (int i = 0; i < n; i++) begin
      gen_pop(s);
      drive(1'b0, 1'b1, s, 1'b0);
    end
  endtask

  task automatic drive_s(input logic r, input logic e, input logic [4:0] d, input logic c);
    rst_s = r; en_s = e; din_s = d; clr_s = c;
    @(posedge CLOCK); #1;
  endtask

  task automatic feed_s(input int n, input logic [4:0] flip);
    logic [4:0] s;
    for (int i = 0; i < n; i++) begin
      gen_pop(s);
      drive_s(1'b0, 1'b1, s ^ flip, 1'b0);
    end
  endtask

  typedef struct {
    logic       en;
    logic       clr;
    logic [4:0] flip;
    logic       locked;
    logic       error;
    int         errc;
    int         symc;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s;
    int err_seen, n_en, lock_at, burst, n2;
    logic e, c, r;

    tbl[0]  = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 0, 1};
    tbl[1]  = '{1'b1, 1'b0, 5'h04, 1'b1, 1'b1, 1, 2};
    tbl[2]  = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 1, 3};
    tbl[3]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1, 3};
    tbl[4]  = '{1'b1, 1'b0, 5'h10, 1'b1, 1'b1, 2, 4};
    tbl[5]  = '{1'b1, 1'b0, 5'h10, 1'b1, 1'b1, 3, 5};
    tbl[6]  = '{1'b1, 1'b0, 5'h10, 1'b1, 1'b1, 4, 6};
    tbl[7]  = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 4, 7};
    tbl[8]  = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b1, 5, 8};
    tbl[9]  = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b1, 6, 9};
    tbl[10] = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b1, 7, 10};
    tbl[11] = '{1'b1, 1'b1, 5'h01, 1'b0, 1'b1, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 0, 0};

    rst_s = 1'b1; en_s = 1'b0; clr_s = 1'b0; din_s = '0;
    g = 19'h1;
    model_reset();

    // Reset held with strobe and clear active.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 5'h1F, 1'b1);
    check("rst_locked", 32'(locked), 0);
    check("rst_errc",   32'(errc),   0);
    rst_s = 1'b0;

    // Lock from generator reset, then 1000 clean symbols.
    feed_good(18);
    check("pre_lock", 32'(locked), 0);
    feed_good(1);
    check("lock_19", 32'(locked), 1);
    err_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      gen_pop(s);
      drive(1'b0, 1'b1, s, 1'b0);
      if (error) err_seen++;
    end
    check("clean_err_seen", 32'(err_seen), 0);
    check("clean_errc", 32'(errc), 0);
    check("clean_symc", 32'(symc), 1000);

    // Directed table: single error, 3-bad/1-good/3-bad, clear with loss of lock.
    drive(1'b0, 1'b0, 5'h00, 1'b1);
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].en) gen_pop(s);
      else s = '0;
      drive(1'b0, tbl[i].en, s ^ tbl[i].flip, tbl[i].clr);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].locked));
      check($sformatf("tbl%0d_error", i),  32'(error),  32'(tbl[i].error));
      check($sformatf("tbl%0d_errc", i),   32'(errc),   32'(tbl[i].errc));
      check($sformatf("tbl%0d_symc", i),   32'(symc),   32'(tbl[i].symc));
    end

    // Relock after 19 good symbols.
    feed_good(18);
    check("relock_18", 32'(locked), 0);
    feed_good(1);
    check("relock_19", 32'(locked), 1);

    // Four consecutive bad symbols drop lock.
    drive(1'b0, 1'b0, 5'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      gen_pop(s);
      drive(1'b0, 1'b1, s ^ 5'h02, 1'b0);
    end
    check("loss3_locked", 32'(locked), 1);
    check("loss3_errc", 32'(errc), 3);
    gen_pop(s);
    drive(1'b0, 1'b1, s ^ 5'h02, 1'b0);
    check("loss4_locked", 32'(locked), 0);
    check("loss4_errc", 32'(errc), 4);
    feed_good(19);
    check("loss_relock", 32'(locked), 1);

    // All-ones lock-up is rejected and acquisition restarts.
    drive(1'b1, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 19; i++) drive(1'b0, 1'b1, 5'h1F, 1'b0);
    check("lockup_locked", 32'(locked), 0);
    feed_good(18);
    check("lockup_18", 32'(locked), 0);
    feed_good(1);
    check("lockup_relock", 32'(locked), 1);

    // Gapped strobes: lock lands on the 19th strobe regardless of gaps.
    drive(1'b1, 1'b0, 5'h00, 1'b0);
    g = 19'h1;
    n_en = 0; lock_at = -1;
    for (int i = 0; i < 2000 && n_en < 19; i++) begin
      e = ($urandom_range(0, 99) < 30);
      if (e) gen_pop(s);
      else s = 5'($urandom);
      drive(1'b0, e, s, 1'b0);
      if (e) n_en++;
      if (locked && lock_at < 0) lock_at = n_en;
    end
    check("gap_lock_at", 32'(lock_at), 19);
    n2 = 0;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 99) < 30);
      if (e) begin gen_pop(s); n2++; end
      else s = 5'($urandom);
      drive(1'b0, e, s, 1'b0);
    end
    check("gap_errc", 32'(errc), 0);
    check("gap_symc", 32'(symc), 32'(n2));

    // Random traffic: sporadic errors, bursts, clears and resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      e = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 99) == 0);
      s = 5'($urandom);
      if (e) begin
        gen_pop(s);
        if (burst > 0) begin
          s = s ^ 5'($urandom_range(1, 31));
          burst--;
        end else if ($urandom_range(0, 19) == 0) begin
          s = s ^ 5'($urandom_range(1, 31));
        end else if ($urandom_range(0, 149) == 0) begin
          burst = 5;
        end
      end
      drive(r, e, s, c);
    end

    // Small counters: saturation and mid-check reset.
    rst = 1'b0; en = 1'b0; clr = 1'b0; din = '0;
    drive_s(1'b1, 1'b0, 5'h00, 1'b0);
    check("s_rst_locked", 32'(locked_s), 0);
    check("s_rst_symc", 32'(symc_s), 0);
    feed_s(19, 5'h00);
    check("s_lock", 32'(locked_s), 1);
    feed_s(30, 5'h00);
    check("s_symc_sat", 32'(symc_s), 15);
    check("s_errc_zero", 32'(errc_s), 0);
    feed_s(20, 5'h01);
    check("s_errc_20bad", 32'(errc_s), 15);
    check("s_locked_20bad", 32'(locked_s), 0);
    feed_s(19, 5'h00);
    check("s_relock", 32'(locked_s), 1);
    drive_s(1'b0, 1'b0, 5'h00, 1'b1);
    check("s_clear_errc", 32'(errc_s), 0);
    feed_s(14, 5'h01);
    feed_s(1, 5'h00);
    feed_s(6, 5'h01);
    check("s_errc_sat", 32'(errc_s), 15);
    check("s_symc_sat2", 32'(symc_s), 15);
    check("s_still_locked", 32'(locked_s), 1);
    check("s_error_pre", 32'(error_s), 1);
    drive_s(1'b1, 1'b1, 5'h1F, 1'b0);
    check("s_midrst_locked", 32'(locked_s), 0);
    check("s_midrst_error", 32'(error_s), 0);
    check("s_midrst_errc", 32'(errc_s), 0);
    check("s_midrst_symc", 32'(symc_s), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
